if_fetch_unit: RTL and testbench
================================

// Module: if_fetch_unit
// PURPOSE
//  Fetch-stage engine feeding the IF/ID latch: owns the PC, issues requests to instruction memory,
//  and presents instruction_out/npc_out/fetch_valid to IF/ID. Honours the hazard-unit stall
//  (pc_write, same net as IFIDWrite) and branch/jump redirects from later stages.
//  Multi-cycle, non-pipelined fetch: one outstanding imem request at a time.
// PARAMETERS
//  RESET_PC   32'h0000_0000  PC loaded on reset
//  NOP_INSTR  32'h0000_0000  instruction_out value whenever no valid fetch is presented
//  PC_INC     32'd4          PC increment per consumed instruction
// PORTS
//  clk             in   1   clock, rising edge
//  rst             in   1   reset, asynchronous, active-high
//  pc_write        in   1   1 = decode may consume / PC may advance; 0 = stall (hold)
//  redirect_valid  in   1   branch/jump taken; overrides stall
//  redirect_pc     in   32  target PC when redirect_valid=1
//  imem_req        out  1   request valid to instruction memory
//  imem_addr       out  32  request address (current PC)
//  imem_ready      in   1   memory accepts request this cycle (imem_req & imem_ready = accept)
//  imem_rvalid     in   1   read data valid; at least 1 cycle after accept
//  imem_rdata      in   32  instruction word
//  instruction_out out  32  registered instruction to IF/ID
//  npc_out         out  32  registered fetched PC + PC_INC
//  fetch_valid     out  1   registered; instruction_out/npc_out hold a live instruction
// BEHAVIOUR
//  Reset: pc=RESET_PC, state=IDLE, instruction_out=NOP_INSTR, npc_out=0, fetch_valid=0,
//   squash=0, imem_req=0. rst mid-transaction abandons any pending response (rvalid ignored in IDLE).
//  imem_req=(state==REQ); imem_addr=pc (combinational from state/pc register).
//  FSM:
//   IDLE : -> REQ next cycle (1-cycle gap after reset release).
//   REQ  : imem_req=1. accept -> WAIT. Redirect same cycle as accept: pc<=redirect_pc, squash<=1.
//          Redirect without accept: pc<=redirect_pc, stay REQ (address changes next cycle).
//   WAIT : rvalid & (squash | redirect_valid) -> discard data, squash<=0, -> REQ.
//          rvalid & clean -> instruction_out<=imem_rdata, npc_out<=pc+PC_INC, fetch_valid<=1, -> OUT.
//          redirect without rvalid -> pc<=redirect_pc, squash<=1, stay WAIT.
//   OUT  : redirect -> pc<=redirect_pc, fetch_valid<=0, instruction_out<=NOP_INSTR, -> REQ.
//          pc_write=1 -> instruction consumed at this edge: pc<=pc+PC_INC, fetch_valid<=0,
//          instruction_out<=NOP_INSTR, -> REQ. pc_write=0 -> hold all outputs, stay OUT.
//  Priority: rst > redirect_valid > pc_write. Redirect in OUT discards presented instruction.
//  Latency: accept at cycle N, rvalid at N+k (k>=1) -> fetch_valid=1 at N+k+1.
//   Best throughput 1 instruction / 3 cycles (REQ, WAIT, OUT).
//  PC arithmetic modulo 2^32: 32'hFFFF_FFFC + 4 wraps to 0. redirect_pc low bits passed unchecked.
//  squash cleared only when the squashed response arrives; never two outstanding requests.
// STRUCTURE
//  Package if_pkg: fetch_state_t {IDLE,REQ,WAIT,OUT} (2-bit), NOP_INSTR, PC_INC, RESET_PC defaults.
//  Sub-module if_pc_reg: PC register with async reset, load(redirect_pc) > inc(+PC_INC) > hold.
//  FSM, squash flag and output registers live in if_fetch_unit.
// TESTING
//  1 Reset then imem_ready=1, rvalid 1 cycle after accept, pc_write=1: addresses 0,4,8;
//    npc_out 4,8,12; fetch_valid pulses 1 cycle each, 3 cycles apart.
//  2 Stall: pc_write=0 for 5 cycles in OUT -> instruction_out/npc_out/fetch_valid stable;
//    no imem_req; release -> next imem_addr = old pc+4.
//  3 Redirect in WAIT to 32'h100 -> stale rdata dropped (fetch_valid stays 0); next imem_addr=32'h100.
//  4 Redirect with pc_write=0 in OUT -> fetch_valid=0, instruction_out=NOP, next addr=redirect_pc.
//  5 imem_ready low 4 cycles -> imem_req/imem_addr held stable; rvalid 3 cycles late -> correct data.
//  6 pc=32'hFFFF_FFFC consumed -> npc_out=0, next imem_addr=0; rst asserted in WAIT -> all outputs
//    reset immediately, late rvalid ignored.

Source files
------------

// File: rtl/if_fetch_unit_pkg.sv
// ============================================================================
// if_pkg : shared fetch-stage types and default constants.   Rev 1.0
// ============================================================================
`default_nettype none

package if_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEF  = 32'h0000_0000;
  localparam logic [31:0] NOP_INSTR_DEF = 32'h0000_0000;
  localparam logic [31:0] PC_INC_DEF    = 32'd4;

endpackage

`default_nettype wire

// File: rtl/if_fetch_unit_pc_reg.sv
// ============================================================================
// if_pc_reg : program counter, load > increment > hold.      Rev 1.0
// ============================================================================
`default_nettype none

module if_pc_reg
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEF,
  parameter logic [31:0] PC_INC   = PC_INC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        load_i,
  input  logic [31:0] load_pc_i,
  input  logic        inc_i,
  output logic [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;

  always_comb begin
    pc_d = pc_q;
    if (load_i) begin
      pc_d = load_pc_i;
    end else if (inc_i) begin
      pc_d = pc_q + PC_INC;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule

`default_nettype wire

// File: rtl/if_fetch_unit.sv
// ============================================================================
// if_fetch_unit : single-outstanding instruction fetch feeding IF/ID.  Rev 1.0
// ============================================================================
`default_nettype none

module if_fetch_unit
  import if_pkg::*;
#(
  parameter logic [31:0] RESET_PC  = RESET_PC_DEF,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF,
  parameter logic [31:0] PC_INC    = PC_INC_DEF
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_write,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction_out,
  output logic [31:0] npc_out,
  output logic        fetch_valid
);

  fetch_state_t state_q, state_d;
  logic         squash_q, squash_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  npc_q, npc_d;
  logic         valid_q, valid_d;
  logic         pc_load;
  logic         pc_inc;
  logic [31:0]  pc;

  if_pc_reg #(
    .RESET_PC (RESET_PC),
    .PC_INC   (PC_INC)
  ) u_pc_reg (
    .clk       (clk),
    .rst       (rst),
    .load_i    (pc_load),
    .load_pc_i (redirect_pc),
    .inc_i     (pc_inc),
    .pc_o      (pc)
  );

  always_comb begin
    state_d  = state_q;
    squash_d = squash_q;
    instr_d  = instr_q;
    npc_d    = npc_q;
    valid_d  = valid_q;
    pc_load  = 1'b0;
    pc_inc   = 1'b0;
    case (state_q)
      IDLE: state_d = REQ;
      REQ: begin
        pc_load = redirect_valid;
        if (imem_ready) begin
          state_d  = WAIT;
          squash_d = redirect_valid;
        end
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (squash_q || redirect_valid) begin
            // Response belongs to an abandoned path; drop it and refetch.
            squash_d = 1'b0;
            pc_load  = redirect_valid;
            state_d  = REQ;
          end else begin
            instr_d = imem_rdata;
            npc_d   = pc + PC_INC;
            valid_d = 1'b1;
            state_d = OUT;
          end
        end else if (redirect_valid) begin
          pc_load  = 1'b1;
          squash_d = 1'b1;
        end
      end
      OUT: begin
        if (redirect_valid) begin
          pc_load = 1'b1;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = REQ;
        end else if (pc_write) begin
          pc_inc  = 1'b1;
          valid_d = 1'b0;
          instr_d = NOP_INSTR;
          state_d = REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      squash_q <= 1'b0;
      instr_q  <= NOP_INSTR;
      npc_q    <= 32'h0000_0000;
      valid_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      squash_q <= squash_d;
      instr_q  <= instr_d;
      npc_q    <= npc_d;
      valid_q  <= valid_d;
    end
  end

  assign imem_req        = (state_q == REQ);
  assign imem_addr       = pc;
  assign instruction_out = instr_q;
  assign npc_out         = npc_q;
  assign fetch_valid     = valid_q;

endmodule

`default_nettype wire

// File: tb/tb_if_fetch_unit.sv
// ============================================================================
// tb_if_fetch_unit : randomized fetch-unit bench with a transaction-level model.  Rev 1.0
// ============================================================================
`default_nettype none

module tb_if_fetch_unit;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        pc_write = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready = 1'b0;
  logic        imem_rvalid = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic [31:0] instruction_out;
  logic [31:0] npc_out;
  logic        fetch_valid;

  if_fetch_unit dut (
    .clk             (clk),
    .rst             (rst),
    .pc_write        (pc_write),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rvalid     (imem_rvalid),
    .imem_rdata      (imem_rdata),
    .instruction_out (instruction_out),
    .npc_out         (npc_out),
    .fetch_valid     (fetch_valid)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] memword(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  // Reference model: architectural PC plus what the fetch unit is doing with it.
  logic [31:0] m_pc, m_instr, m_npc;
  logic        m_gap, m_busy, m_stale, m_have;

  task automatic model_reset();
    m_pc = 32'h0; m_instr = 32'h0; m_npc = 32'h0;
    m_gap = 1'b1; m_busy = 1'b0; m_stale = 1'b0; m_have = 1'b0;
  endtask

  task automatic model_step(input logic pw, input logic rv, input logic [31:0] rpc,
                            input logic rdy, input logic rvl, input logic [31:0] rd);
    if (m_gap) begin
      m_gap = 1'b0;
    end else if (m_busy) begin
      if (rvl) begin
        m_busy = 1'b0;
        if (m_stale || rv) begin
          m_stale = 1'b0;
          if (rv) m_pc = rpc;
        end else begin
          m_have  = 1'b1;
          m_instr = rd;
          m_npc   = m_pc + 32'd4;
        end
      end else if (rv) begin
        m_pc    = rpc;
        m_stale = 1'b1;
      end
    end else if (m_have) begin
      if (rv) begin
        m_have = 1'b0;
        m_pc   = rpc;
      end else if (pw) begin
        m_have = 1'b0;
        m_pc   = m_pc + 32'd4;
      end
    end else begin
      if (rdy) begin
        m_busy  = 1'b1;
        m_stale = rv;
      end
      if (rv) m_pc = rpc;
    end
  endtask

  // Single compare process: every cycle, DUT outputs against the model.
  always @(negedge clk) begin
    check("imem_req", {31'b0, imem_req}, {31'b0, !(m_gap || m_busy || m_have)});
    check("imem_addr", imem_addr, m_pc);
    check("fetch_valid", {31'b0, fetch_valid}, {31'b0, m_have});
    check("instruction_out", instruction_out, m_have ? m_instr : 32'h0);
    check("npc_out", npc_out, m_npc);
    if (fetch_valid) check("instr_vs_mem", instruction_out, memword(npc_out - 32'd4));
  end

  // Memory responder state and logs
  logic        r_pend = 1'b0;
  int          r_cnt  = 0;
  logic [31:0] r_data = '0;
  int          lat    = 1;
  int          cyc    = 0;
  logic        acc_flag;
  logic        prev_valid = 1'b0;
  logic [31:0] acc_q[$];
  logic [31:0] npc_log[$];
  int          vcyc_log[$];

  task automatic step(input logic pw, input logic rv, input logic [31:0] rpc, input logic rdy);
    logic        acc, fire;
    logic [31:0] a, rd;
    pc_write       = pw;
    redirect_valid = rv;
    redirect_pc    = rpc;
    imem_ready     = rdy;
    if (r_pend && r_cnt == 0) begin
      imem_rvalid = 1'b1;
      imem_rdata  = r_data;
    end else begin
      imem_rvalid = 1'b0;
      imem_rdata  = $urandom;
    end
    acc  = imem_req && rdy && !rst;
    a    = imem_addr;
    fire = imem_rvalid;
    rd   = imem_rdata;
    @(posedge clk);
    #1;
    cyc++;
    model_step(pw, rv, rpc, rdy, fire, rd);
    if (fire) r_pend = 1'b0;
    else if (r_pend) r_cnt--;
    acc_flag = acc;
    if (acc) begin
      r_pend = 1'b1;
      r_cnt  = lat - 1;
      r_data = memword(a);
      acc_q.push_back(a);
    end
    if (fetch_valid && !prev_valid) begin
      npc_log.push_back(npc_out);
      vcyc_log.push_back(cyc);
    end
    prev_valid = fetch_valid;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    r_pend = 1'b0;
    prev_valid = 1'b0;
    imem_rvalid = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  task automatic run_until_valid(input logic pw, input logic rdy);
    int n = 0;
    while (!fetch_valid && n < 40) begin
      step(pw, 1'b0, 32'h0, rdy);
      n++;
    end
    check("timeout_valid", {31'b0, fetch_valid}, 32'd1);
  endtask

  task automatic run_until_acc(input logic pw);
    int n = 0;
    acc_flag = 1'b0;
    while (!acc_flag && n < 40) begin
      step(pw, 1'b0, 32'h0, 1'b1);
      n++;
    end
    check("timeout_accept", {31'b0, acc_flag}, 32'd1);
  endtask

  logic [31:0] save_i, save_n;

  initial begin
    model_reset();
    // 1: back-to-back fetches
    do_reset();
    check("rst_fetch_valid", {31'b0, fetch_valid}, 32'd0);
    check("rst_npc", npc_out, 32'h0);
    acc_q.delete(); npc_log.delete(); vcyc_log.delete();
    lat = 1;
    repeat (10) step(1'b1, 1'b0, 32'h0, 1'b1);
    check("t1_addr0", acc_q[0], 32'h0);
    check("t1_addr1", acc_q[1], 32'h4);
    check("t1_addr2", acc_q[2], 32'h8);
    check("t1_npc0", npc_log[0], 32'd4);
    check("t1_npc1", npc_log[1], 32'd8);
    check("t1_npc2", npc_log[2], 32'd12);
    check("t1_spacing01", vcyc_log[1] - vcyc_log[0], 32'd3);
    check("t1_spacing12", vcyc_log[2] - vcyc_log[1], 32'd3);

    // 2: stall in OUT
    run_until_valid(1'b0, 1'b1);
    save_i = instruction_out;
    save_n = npc_out;
    repeat (5) begin
      step(1'b0, 1'b0, 32'h0, 1'b1);
      check("t2_hold_instr", instruction_out, save_i);
      check("t2_hold_npc", npc_out, save_n);
      check("t2_hold_valid", {31'b0, fetch_valid}, 32'd1);
      check("t2_no_req", {31'b0, imem_req}, 32'd0);
    end
    step(1'b1, 1'b0, 32'h0, 1'b1);
    check("t2_next_addr", imem_addr, save_n);
    check("t2_req", {31'b0, imem_req}, 32'd1);

    // 3: redirect while waiting for data
    lat = 3;
    run_until_acc(1'b1);
    step(1'b1, 1'b1, 32'h100, 1'b1);
    check("t3_valid_low", {31'b0, fetch_valid}, 32'd0);
    check("t3_addr", imem_addr, 32'h100);
    lat = 1;
    run_until_acc(1'b1);
    check("t3_refetch_addr", acc_q[$], 32'h100);
    run_until_valid(1'b0, 1'b1);
    check("t3_npc", npc_out, 32'h104);

    // 4: redirect while stalled in OUT
    step(1'b0, 1'b1, 32'h200, 1'b1);
    check("t4_valid", {31'b0, fetch_valid}, 32'd0);
    check("t4_nop", instruction_out, 32'h0);
    check("t4_addr", imem_addr, 32'h200);

    // 5: memory back-pressure and slow response
    repeat (4) begin
      step(1'b1, 1'b0, 32'h0, 1'b0);
      check("t5_req_held", {31'b0, imem_req}, 32'd1);
      check("t5_addr_held", imem_addr, 32'h200);
    end
    lat = 3;
    step(1'b1, 1'b0, 32'h0, 1'b1);
    run_until_valid(1'b0, 1'b1);
    check("t5_instr", instruction_out, memword(32'h200));
    check("t5_npc", npc_out, 32'h204);
    step(1'b1, 1'b0, 32'h0, 1'b1);

    // 6: PC wrap, then reset in the middle of a transaction
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0);
    lat = 1;
    run_until_valid(1'b0, 1'b1);
    check("t6_wrap_npc", npc_out, 32'h0);
    check("t6_wrap_instr", instruction_out, memword(32'hFFFF_FFFC));
    step(1'b1, 1'b0, 32'h0, 1'b0);
    check("t6_wrap_addr", imem_addr, 32'h0);
    step(1'b0, 1'b1, 32'h300, 1'b0);
    run_until_valid(1'b1, 1'b1);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    lat = 4;
    run_until_acc(1'b1);
    check("t6_model_pin", m_pc, 32'h304);
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check("t6_rst_npc", npc_out, 32'h0);
    check("t6_rst_addr", imem_addr, 32'h0);
    check("t6_rst_req", {31'b0, imem_req}, 32'd0);
    check("t6_rst_valid", {31'b0, fetch_valid}, 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    prev_valid = 1'b0;
    repeat (6) step(1'b1, 1'b0, 32'h0, 1'b0);
    check("t6_late_ignored", {31'b0, fetch_valid}, 32'd0);
    lat = 1;
    run_until_valid(1'b0, 1'b1);
    check("t6_after_rst_npc", npc_out, 32'h4);
    check("t6_after_rst_instr", instruction_out, memword(32'h0));

    // Randomized traffic
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      logic        rv;
      logic [31:0] rpc;
      lat = $urandom_range(1, 4);
      rv  = ($urandom_range(0, 9) == 0);
      rpc = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : ($urandom & 32'h0000_FFFC);
      step($urandom_range(0, 2) != 0, rv, rpc, $urandom_range(0, 3) != 0);
    end

    @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
